// File: rtl/md_if.sv
// E-stage multiply/divide bus: issue signals from the pipeline and the
// Busy/HI/LO state returned by md_unit.
interface md_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDOp, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit: computes the result at issue, holds it
// for MULT_CYCLES/DIV_CYCLES to model latency, then commits to HI/LO.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic Clk,
  input  logic Reset,
  md_if.slave  md
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  md_op_e      op;
  logic        idle;
  logic        b_zero;

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ph_q, ph_d, pl_q, pl_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;

  logic signed [63:0] a_ext_s, b_ext_s, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;

  assign op     = md_op_e'(md.MDOp);
  assign idle   = (cnt_q == 4'd0);
  assign b_zero = (md.B == 32'd0);

  assign a_ext_s = {{32{md.A[31]}}, md.A};
  assign b_ext_s = {{32{md.B[31]}}, md.B};
  assign prod_s  = a_ext_s * b_ext_s;
  assign prod_u  = {32'd0, md.A} * {32'd0, md.B};

  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (!b_zero) begin
      quo_u = md.A / md.B;
      rem_u = md.A % md.B;
      // Most-negative / -1 overflows; give the wrapped quotient explicitly.
      if (md.A == 32'h8000_0000 && md.B == 32'hFFFF_FFFF) begin
        quo_s = 32'sh8000_0000;
        rem_s = 32'sd0;
      end else begin
        quo_s = $signed(md.A) / $signed(md.B);
        rem_s = $signed(md.A) % $signed(md.B);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    pl_d  = pl_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dz_d  = dz_q;

    if (!idle) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && !dz_q) begin
        hi_d = ph_q;
        lo_d = pl_q;
      end
    end else if (md.Start) begin
      unique case (op)
        OP_MULT: begin
          {ph_d, pl_d} = prod_s;
          dz_d  = 1'b0;
          cnt_d = 4'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {ph_d, pl_d} = prod_u;
          dz_d  = 1'b0;
          cnt_d = 4'(MULT_CYCLES);
        end
        OP_DIV: begin
          ph_d  = rem_s;
          pl_d  = quo_s;
          dz_d  = b_zero;
          cnt_d = 4'(DIV_CYCLES);
        end
        OP_DIVU: begin
          ph_d  = rem_u;
          pl_d  = quo_u;
          dz_d  = b_zero;
          cnt_d = 4'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = md.A;
        OP_MTLO: lo_d = md.A;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      ph_q  <= '0;
      pl_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
      pl_q  <= pl_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dz_q  <= dz_d;
    end
  end

  assign md.Busy = !idle;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo, holds the HI/LO architectural registers, and models multi-cycle latency.
- Drives Busy, which the hazard unit combines with the E-stage Start pulse to stall mfhi/mflo/md instructions in D.
- The E-stage result mux reads HI and LO for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu (range 1..15).
- DIV_CYCLES, 10, Busy duration in cycles for div/divu (range 1..15).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; the E-stage instruction is an md operation (op given by MDOp).
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- Busy  output  1  high while a mult/div is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (Reset=0, asynchronous):
  - Busy=0, HI=0, LO=0, cycle counter=0, pending result=0.
  - Applies immediately regardless of Clk.
  - An in-flight operation is discarded; HI/LO stay 0 after release.
- State:
  - 4-bit down-counter cnt; Busy = (cnt != 0), registered, never combinational from Start.
  - 64-bit pending register {PH, PL}.
- Accept: at a rising edge with Start=1, Busy=0 and MDOp in 1..4:
  - Compute the result from A/B sampled that edge into {PH, PL}.
  - Load cnt with MULT_CYCLES (ops 1/2) or DIV_CYCLES (ops 3/4).
- Arithmetic:
  - mult: signed 32x32 to 64-bit; PH=product[63:32], PL=product[31:0].
  - multu: the same, unsigned.
  - div: PL=quotient truncated toward zero; PH=remainder, which takes the sign of the dividend A.
  - divu: unsigned quotient/remainder.
  - Divide by zero (B=0): the counter still runs the full DIV_CYCLES, then HI/LO are left unchanged (no commit).
- Countdown: each edge with cnt != 0 decrements cnt.
  - At the edge where cnt goes 1 to 0, HI<=PH and LO<=PL, unless the op was div-by-zero.
  - Busy falls at that same edge, so new HI/LO are visible in the first cycle Busy=0.
- Latency: the Start edge is T0; Busy=1 during cycles T0+1 .. T0+N; HI/LO are updated at edge T0+N. Stall window (Busy|Start) is N+1 cycles.
- mthi/mtlo: at an edge with Start=1, Busy=0 and MDOp=5/6, HI<=A (5) or LO<=A (6) immediately. Busy stays 0; the counter is not touched.
- Start while Busy=1: ignored entirely, with no change to counter, pending or HI/LO. The hazard unit prevents this; verification checks the ignore.
- Start with MDOp=0/7: no effect.
- Zero-duration parameters are illegal; behaviour is undefined.

Test Plan:
- Reset, A=0xFFFFFFFE (-2), B=3, Start+mult -> Busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA when Busy falls; before that HI/LO=0.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div with A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then divu with A=7, B=0 -> Busy 10 cycles, HI/LO unchanged.
- mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0 -> HI/LO update at the respective edges; Busy never asserts.
- mult in flight (cycle 2 of 5); pulse Start+mtlo A=0x1 -> ignored; final LO equals the mult result, not 0x1.
- div in flight (cycle 4); drive Reset=0 between clock edges -> Busy, HI, LO go 0 immediately; after release with no Start, they stay 0 for 15 cycles.
